// File: rtl/dpd_lms_update.sv
// rtl/dpd_lms_update.sv - block-LMS coefficient adaptation for the memory-polynomial DPD
// Correlates basis terms with conj(error) over 2^LOG2_N valid samples, then updates one tap per cycle.
module dpd_lms_update #(
  parameter int NTAPS    = 15,
  parameter int W        = 20,
  parameter int LOG2_N   = 10,
  parameter int MU_SH    = 12,
  parameter int ACC_W    = 52,
  parameter int INIT_TAP = 2,
  parameter int ONE_VAL  = 262144
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [NTAPS*W-1:0] yy_i_i,
  input  logic [NTAPS*W-1:0] yy_q_i,
  input  logic [W-1:0]       err_i_i,
  input  logic [W-1:0]       err_q_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               ld_i,
  input  logic [3:0]         ld_addr_i,
  input  logic [W-1:0]       ld_i_i,
  input  logic [W-1:0]       ld_q_i,
  output logic [NTAPS*W-1:0] coeff_i_o,
  output logic [NTAPS*W-1:0] coeff_q_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               sat_flag_o
);

  localparam int SH = LOG2_N + MU_SH;

  typedef enum logic [1:0] {IDLE, ACCUM, UPDATE, DONE} state_t;

  state_t              state_q, state_d;
  logic [LOG2_N-1:0]   cnt_q, cnt_d;
  logic [3:0]          tap_q, tap_d;
  logic                sat_q;
  logic signed [ACC_W-1:0] acc_re_q [NTAPS];
  logic signed [ACC_W-1:0] acc_im_q [NTAPS];
  logic signed [W-1:0]     coef_i_q [NTAPS];
  logic signed [W-1:0]     coef_q_q [NTAPS];

  logic signed [2*W-1:0] p_ii [NTAPS];
  logic signed [2*W-1:0] p_qq [NTAPS];
  logic signed [2*W-1:0] p_qi [NTAPS];
  logic signed [2*W-1:0] p_iq [NTAPS];

  logic       acc_en, clr_en, upd_en, ld_en;
  logic [W:0] upd_i, upd_q;

  // Returns {clamped, value}: coefficient plus the scaled correlation, saturated to W bits.
  function automatic logic [W:0] sat_add(input logic signed [W-1:0] c,
                                         input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W:0] s;
    s = (ACC_W+1)'(c) + (ACC_W+1)'(a >>> SH);
    if (s > (ACC_W+1)'($signed({1'b0, {(W-1){1'b1}}})))
      sat_add = {1'b1, 1'b0, {(W-1){1'b1}}};
    else if (s < (ACC_W+1)'($signed({1'b1, {(W-1){1'b0}}})))
      sat_add = {1'b1, 1'b1, {(W-1){1'b0}}};
    else
      sat_add = {1'b0, s[W-1:0]};
  endfunction

  always_comb begin
    for (int k = 0; k < NTAPS; k++) begin
      p_ii[k] = (2*W)'($signed(yy_i_i[k*W +: W])) * (2*W)'($signed(err_i_i));
      p_qq[k] = (2*W)'($signed(yy_q_i[k*W +: W])) * (2*W)'($signed(err_q_i));
      p_qi[k] = (2*W)'($signed(yy_q_i[k*W +: W])) * (2*W)'($signed(err_i_i));
      p_iq[k] = (2*W)'($signed(yy_i_i[k*W +: W])) * (2*W)'($signed(err_q_i));
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tap_d   = tap_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = ACCUM;
          cnt_d   = '0;
        end
      end
      ACCUM: begin
        if (en_i) begin
          cnt_d = cnt_q + LOG2_N'(1);
          if (cnt_q == '1) begin
            state_d = UPDATE;
            tap_d   = '0;
          end
        end
      end
      UPDATE: begin
        tap_d = tap_q + 4'd1;
        if (tap_q == 4'(NTAPS-1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tap_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tap_q   <= tap_d;
    end
  end

  // Abort suppresses every side effect of the cycle it arrives in.
  assign acc_en = (state_q == ACCUM)  && en_i    && !abort_i;
  assign clr_en = (state_q == IDLE)   && start_i && !abort_i;
  assign upd_en = (state_q == UPDATE) && !abort_i;
  assign ld_en  = (state_q == IDLE) && ld_i && !start_i && !abort_i &&
                  ({1'b0, ld_addr_i} < 5'(NTAPS));

  assign upd_i = sat_add(coef_i_q[tap_q], acc_re_q[tap_q]);
  assign upd_q = sat_add(coef_q_q[tap_q], acc_im_q[tap_q]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NTAPS; k++) begin
        acc_re_q[k] <= '0;
        acc_im_q[k] <= '0;
        coef_i_q[k] <= (k == INIT_TAP) ? W'(ONE_VAL) : '0;
        coef_q_q[k] <= '0;
      end
      sat_q <= 1'b0;
    end else begin
      if (clr_en) begin
        for (int k = 0; k < NTAPS; k++) begin
          acc_re_q[k] <= '0;
          acc_im_q[k] <= '0;
        end
        sat_q <= 1'b0;
      end else if (acc_en) begin
        for (int k = 0; k < NTAPS; k++) begin
          acc_re_q[k] <= acc_re_q[k] + ACC_W'(p_ii[k]) + ACC_W'(p_qq[k]);
          acc_im_q[k] <= acc_im_q[k] + ACC_W'(p_qi[k]) - ACC_W'(p_iq[k]);
        end
      end
      if (upd_en) begin
        coef_i_q[tap_q] <= upd_i[W-1:0];
        coef_q_q[tap_q] <= upd_q[W-1:0];
        if (upd_i[W] || upd_q[W]) sat_q <= 1'b1;
      end else if (ld_en) begin
        coef_i_q[ld_addr_i] <= ld_i_i;
        coef_q_q[ld_addr_i] <= ld_q_i;
      end
    end
  end

  always_comb begin
    coeff_i_o = '0;
    coeff_q_o = '0;
    for (int k = 0; k < NTAPS; k++) begin
      coeff_i_o[k*W +: W] = coef_i_q[k];
      coeff_q_o[k*W +: W] = coef_q_q[k];
    end
  end

  assign busy_o     = (state_q == ACCUM) || (state_q == UPDATE);
  assign done_o     = (state_q == DONE);
  assign sat_flag_o = sat_q;

endmodule

// File: tb/tb_dpd_lms_update.sv
// tb/tb_dpd_lms_update.sv - directed table-driven bench for dpd_lms_update
// Uses a 4-sample block (LOG2_N=2) with unity step (MU_SH=0) so results are easy to hand-derive.
module tb_dpd_lms_update;
  localparam int NTAPS = 15;
  localparam int W     = 20;

  logic               clk;
  logic               rst, en, start, abort, ld;
  logic [NTAPS*W-1:0] yy_i, yy_q;
  logic [W-1:0]       err_i, err_q, ld_di, ld_dq;
  logic [3:0]         ld_addr;
  logic [NTAPS*W-1:0] coeff_i, coeff_q;
  logic               busy, done, sat;

  int     checks = 0;
  int     failures = 0;
  longint exp_i [NTAPS];
  longint exp_q [NTAPS];

  typedef struct {
    int     yi, yq, ei, eq;
    bit     gap, one_shot;
    longint di, dq;
    bit     sat;
  } vec_t;
  vec_t tbl [9];

  dpd_lms_update #(.NTAPS(NTAPS), .W(W), .LOG2_N(2), .MU_SH(0), .ACC_W(52),
                   .INIT_TAP(2), .ONE_VAL(262144)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .yy_i_i(yy_i), .yy_q_i(yy_q),
    .err_i_i(err_i), .err_q_i(err_q), .start_i(start), .abort_i(abort),
    .ld_i(ld), .ld_addr_i(ld_addr), .ld_i_i(ld_di), .ld_q_i(ld_dq),
    .coeff_i_o(coeff_i), .coeff_q_o(coeff_q), .busy_o(busy), .done_o(done),
    .sat_flag_o(sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic signed [63:0] act, input longint expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  task automatic chk_coef(input string name);
    logic [NTAPS*W-1:0] pi, pq;
    for (int k = 0; k < NTAPS; k++) begin
      pi[k*W +: W] = W'(exp_i[k]);
      pq[k*W +: W] = W'(exp_q[k]);
    end
    checks++;
    if (coeff_i !== pi || coeff_q !== pq) begin
      failures++;
      $display("FAIL %s coeff_i=%h coeff_q=%h expected_i=%h expected_q=%h",
               name, coeff_i, coeff_q, pi, pq);
    end
  endtask

  function automatic longint sat_w(input longint v);
    if (v > 524287) return 524287;
    if (v < -524288) return -524288;
    return v;
  endfunction

  task automatic exp_reset();
    for (int k = 0; k < NTAPS; k++) begin
      exp_i[k] = (k == 2) ? 262144 : 0;
      exp_q[k] = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; start = 1'b0; abort = 1'b0; ld = 1'b0; ld_addr = '0;
    ld_di = '0; ld_dq = '0; err_i = '0; err_q = '0; yy_i = '0; yy_q = '0;
    tick();
    rst = 1'b0;
    exp_reset();
  endtask

  task automatic set_yy(input int yi, input int yq);
    logic [W-1:0] ti, tq;
    ti = W'(yi);
    tq = W'(yq);
    yy_i = {NTAPS{ti}};
    yy_q = {NTAPS{tq}};
  endtask

  task automatic do_ld(input int addr, input int di, input int dq);
    ld = 1'b1; ld_addr = 4'(addr); ld_di = W'(di); ld_dq = W'(dq);
    tick();
    ld = 1'b0;
  endtask

  // Full block; en is held high after the last sample to show UPDATE ignores it.
  task automatic run_block(input int yi, input int yq, input int ei, input int eq,
                           input bit gap, input bit one_shot, output int lat);
    set_yy(yi, yq);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int s = 0; s < 4; s++) begin
      en    = 1'b1;
      err_i = (one_shot && s > 0) ? '0 : W'(ei);
      err_q = (one_shot && s > 0) ? '0 : W'(eq);
      if (s < 3) begin
        tick();
        if (gap) begin
          en = 1'b0; err_i = W'(777); err_q = W'(-333);
          tick();
        end
      end
    end
    lat = 0;
    do begin
      tick();
      lat++;
    end while (done !== 1'b1 && lat < 40);
    en = 1'b0;
    tick();
  endtask

  task automatic watch_done(input int n, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < n; c++) begin
      tick();
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  initial begin
    int lat;
    bit seen;

    tbl[0] = '{1000, 0, 4, 0, 1'b0, 1'b0, 4000, 0, 1'b0};
    tbl[1] = '{1000, 0, 0, 4, 1'b0, 1'b0, 0, -4000, 1'b0};
    tbl[2] = '{1000, 0, 4, 0, 1'b1, 1'b0, 4000, 0, 1'b0};
    tbl[3] = '{0, 500, 3, 0, 1'b0, 1'b0, 0, 1500, 1'b0};
    tbl[4] = '{1000, -2000, 3, 5, 1'b0, 1'b0, -7000, -11000, 1'b0};
    tbl[5] = '{1, 0, -1, 0, 1'b0, 1'b1, -1, 0, 1'b0};
    tbl[6] = '{1, 0, 1, 0, 1'b0, 1'b1, 0, 0, 1'b0};
    tbl[7] = '{524287, 0, 524287, 0, 1'b0, 1'b0, 64'sd274876858369, 0, 1'b1};
    tbl[8] = '{524287, 0, -524288, 0, 1'b0, 1'b0, -64'sd274877382656, 0, 1'b1};

    rst = 1'b1;
    do_reset();
    chk_coef("reset_coeff");
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_sat", sat, 0);

    for (int v = 0; v < 9; v++) begin
      do_reset();
      run_block(tbl[v].yi, tbl[v].yq, tbl[v].ei, tbl[v].eq, tbl[v].gap, tbl[v].one_shot, lat);
      chk($sformatf("vec%0d_done_latency", v), lat, 16);
      chk($sformatf("vec%0d_done_pulse", v), done, 0);
      chk($sformatf("vec%0d_busy_after", v), busy, 0);
      for (int k = 0; k < NTAPS; k++) begin
        exp_i[k] = sat_w(exp_i[k] + tbl[v].di);
        exp_q[k] = sat_w(exp_q[k] + tbl[v].dq);
      end
      chk_coef($sformatf("vec%0d_coeff", v));
      chk($sformatf("vec%0d_sat", v), sat, tbl[v].sat);
    end

    // Saturating tap, sat_flag clear on start, then reset in the middle of ACCUM.
    do_reset();
    do_ld(0, 524287, 0);
    exp_i[0] = 524287;
    chk_coef("ld_idle_tap0");
    run_block(1000, 0, 4, 0, 1'b0, 1'b0, lat);
    for (int k = 1; k < NTAPS; k++) exp_i[k] += 4000;
    chk_coef("sat_tap0_hold");
    chk("sat_set", sat, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_clears_sat", sat, 0);
    chk("busy_accum", busy, 1);
    en = 1'b1;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    exp_reset();
    chk_coef("async_reset_coeff");
    chk("async_reset_busy", busy, 0);
    chk("async_reset_done", done, 0);
    chk("async_reset_sat", sat, 0);
    tick();
    rst = 1'b0;
    en = 1'b0;

    // Abort in ACCUM with a dropped ld, then ld rules in IDLE.
    do_reset();
    set_yy(1000, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    en = 1'b1; err_i = W'(4); err_q = '0;
    ld = 1'b1; ld_addr = 4'd3; ld_di = W'(111); ld_dq = W'(222);
    tick();
    ld = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    en = 1'b0;
    chk("abort_accum_idle", busy, 0);
    chk_coef("abort_accum_ld_ignored");
    watch_done(20, seen);
    chk("abort_accum_no_done", seen, 0);
    do_ld(3, 111, 222);
    exp_i[3] = 111; exp_q[3] = 222;
    chk_coef("ld_idle_tap3");
    do_ld(15, 9, 9);
    chk_coef("ld_addr_out_of_range");
    ld = 1'b1; ld_addr = 4'd4; ld_di = W'(5); ld_dq = W'(5);
    start = 1'b1;
    tick();
    start = 1'b0; ld = 1'b0;
    chk("start_beats_ld_busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_coef("start_beats_ld_coeff");

    // Abort partway through UPDATE: taps 0 and 1 written, tap 2 onward untouched.
    start = 1'b1;
    tick();
    start = 1'b0;
    en = 1'b1; err_i = W'(4); err_q = '0;
    for (int s = 0; s < 4; s++) tick();
    chk_coef("first_update_latency_1");
    tick();
    exp_i[0] += 4000;
    chk_coef("first_update_latency_2");
    tick();
    exp_i[1] += 4000;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    en = 1'b0;
    chk("abort_update_idle", busy, 0);
    chk_coef("abort_update_coeff");
    watch_done(20, seen);
    chk("abort_update_no_done", seen, 0);
    chk_coef("abort_update_coeff_stable");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
